// File: rtl/polygon_area.sv
// polygon_area: stores LENGTH ordered vertices and computes twice the
// enclosed area with the shoelace formula, one cross term per cycle, plus
// the winding direction (cw=1 for clockwise order).
module polygon_area #(
  parameter int unsigned LENGTH = 6,
  parameter int unsigned WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               give_valid,
  input  logic [WIDTH-1:0]   dataX,
  input  logic [WIDTH-1:0]   dataY,
  output logic               in_ready,
  output logic [2*WIDTH:0]   area_x2,
  output logic               cw,
  output logic               out_valid
);

  localparam int unsigned CNT_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH + 2;
  localparam int unsigned ACC_W  = 2 * WIDTH + 4;
  localparam int unsigned OUT_W  = 2 * WIDTH + 1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_d;
  logic [CNT_W-1:0]        vcnt;
  logic [CNT_W-1:0]        idx;
  logic [CNT_W-1:0]        idx_nxt;
  logic [WIDTH-1:0]        x_mem [LENGTH];
  logic [WIDTH-1:0]        y_mem [LENGTH];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_abs;
  logic signed [WIDTH:0]   xk;
  logic signed [WIDTH:0]   yk;
  logic signed [WIDTH:0]   xn;
  logic signed [WIDTH:0]   yn;
  logic signed [PROD_W-1:0] p_a;
  logic signed [PROD_W-1:0] p_b;
  logic signed [PROD_W-1:0] term;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      S_LOAD:  if (give_valid && (vcnt == LAST)) state_d = S_CALC;
      S_CALC:  if (idx == LAST) state_d = S_FINAL;
      S_FINAL: state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Shoelace cross term for index idx and its successor (wraps to 0)
  always_comb begin
    idx_nxt = (idx == LAST) ? '0 : idx + CNT_W'(1);
    xk      = $signed({1'b0, x_mem[idx]});
    yk      = $signed({1'b0, y_mem[idx]});
    xn      = $signed({1'b0, x_mem[idx_nxt]});
    yn      = $signed({1'b0, y_mem[idx_nxt]});
    p_a     = PROD_W'(xk) * PROD_W'(yn);
    p_b     = PROD_W'(xn) * PROD_W'(yk);
    term    = p_a - p_b;
    acc_d   = acc + ACC_W'(term);
    acc_abs = acc[ACC_W-1] ? -acc : acc;
  end

  // Vertex capture, accumulation and registered result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt      <= '0;
      idx       <= '0;
      acc       <= '0;
      area_x2   <= '0;
      cw        <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      for (int i = 0; i < int'(LENGTH); i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      in_ready  <= (state_d == S_LOAD);
      case (state)
        S_LOAD: begin
          if (give_valid) begin
            x_mem[vcnt] <= dataX;
            y_mem[vcnt] <= dataY;
            if (vcnt == LAST) begin
              vcnt <= '0;
              idx  <= '0;
              acc  <= '0;
            end else begin
              vcnt <= vcnt + CNT_W'(1);
            end
          end
        end
        S_CALC: begin
          acc <= acc_d;
          idx <= idx_nxt;
        end
        S_FINAL: begin
          area_x2   <= OUT_W'(acc_abs);
          cw        <= acc[ACC_W-1];
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/polygon_area.md
Name: polygon_area

Overview:
- Downstream of the counter-clockwise vertex sorter.
- Consumes the ordered vertex stream (sorter's ansX/ansY/out_valid drive dataX/dataY/give_valid) and stores LENGTH vertices.
- Computes twice the enclosed polygon area with the shoelace formula, one cross term per cycle, then emits the result with a one-cycle valid pulse.
- Also reports winding direction, so the sorter's output ordering can be checked in-system.

Parameters:
- LENGTH, 6, vertices per polygon; legal range 3..8.
- WIDTH, 8, bits per unsigned coordinate.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: asserted (0) clears all state immediately, independent of clk; released synchronously to clk.
- give_valid  input  1  vertex present on dataX/dataY this cycle.
- dataX  input  WIDTH  vertex X, unsigned.
- dataY  input  WIDTH  vertex Y, unsigned.
- in_ready  output  1  high while in LOAD; vertex accepted on an edge where give_valid and in_ready are both 1.
- area_x2  output  2*WIDTH+1  |shoelace sum| = twice polygon area, unsigned.
- cw  output  1  1 when signed sum < 0 (clockwise order), else 0.
- out_valid  output  1  one-cycle pulse, area_x2/cw valid.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - state=LOAD, vertex counter=0, term index=0, accumulator=0.
  - All vertex registers=0.
  - Outputs: area_x2=0, cw=0, out_valid=0. in_ready=1, decoded from state.
- States: LOAD -> CALC -> FINAL -> LOAD.
- LOAD:
  - On an accepting edge, store (dataX,dataY) at index vcnt, then vcnt+1.
  - Gaps in give_valid stall; no timeout.
  - The edge accepting vertex LENGTH-1 moves to CALC, with vcnt=0, idx=0, acc=0.
- CALC, edge k for k=0..LENGTH-1:
  - acc += x[k]*y[n] - x[n]*y[k], with n = (k==LENGTH-1) ? 0 : k+1 (wrap-around term).
  - After k=LENGTH-1, go to FINAL.
- FINAL, one edge:
  - area_x2 <= |acc|, cw <= acc[MSB], out_valid <= 1.
  - state -> LOAD.
- out_valid:
  - Deasserts on the next edge; it is never high for two consecutive cycles.
  - area_x2/cw hold their value until the next FINAL.
- Latency: the edge accepting the last vertex is E0; out_valid is high in the cycle after edge E(LENGTH+1). Default: 7 edges, i.e. 8 cycles from last vertex accepted to result visible.
- Throughput: in_ready is 1 during the out_valid cycle, so a back-to-back vertex is accepted there. Next polygon may start immediately.
- give_valid while in_ready=0 (CALC/FINAL): vertex ignored and dropped, no state change.
- Arithmetic widths:
  - Coordinates are zero-extended to signed WIDTH+1 bits.
  - Products are signed 2*WIDTH+2 bits.
  - Accumulator is signed 2*WIDTH+4 bits, so there is no overflow for LENGTH<=8.
  - |acc| truncated to 2*WIDTH+1 bits is exact for any simple polygon in the coordinate box; max 2*255*255 = 130050.
- Degenerate input (collinear or repeated points): area_x2=0, cw=0.
- Reset mid-LOAD or mid-CALC: partial polygon discarded, no out_valid; next accepted vertex is index 0.

Test Plan:
- Stream (0,0),(4,0),(6,3),(4,6),(0,6),(0,3), give_valid held high -> out_valid pulse exactly 8 cycles after last accept; area_x2=60, cw=0; in_ready=0 for 7 cycles only.
- Same six points in reverse order -> area_x2=60, cw=1.
- Collinear points (0,0),(1,1),(2,2),(3,3),(4,4),(5,5) -> area_x2=0, cw=0.
- Corners (0,0),(255,0),(255,255),(0,255),(0,255),(0,0) -> area_x2=130050 (0x1FC02), cw=0; no overflow.
- Repeat test 1 with give_valid gaps of 0-3 random cycles; pulse give_valid during CALC -> identical result; CALC-phase vertices dropped; next polygon starts on first vertex accepted in LOAD, including the out_valid cycle.
- Assert reset after 3 vertices, then release and stream test 1 -> no out_valid from the aborted polygon; result area_x2=60. Assert reset during CALC -> outputs return to 0 immediately, without waiting for clk.
